// File: rtl/bonus_ship_pkg.sv
// Shared types and constants for the bonus (mystery) ship controller.
package bonus_ship_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FLY,
        EXPLODE
    } shipState_t;

    // Fibonacci feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [8:0] SCORE_TABLE [4] = '{9'd50, 9'd100, 9'd150, 9'd300};

    // Largest 2^k-1 whose 2^k still fits inside the spawn window.
    function automatic int spawnMask(input int span);
        int mask;
        mask = 0;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) <= span) mask = (1 << k) - 1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bonus_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed while resetN is high.
module bonus_lfsr16
    import bonus_ship_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (resetN) q <= seed;
        else        q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/bonus_ship_sequencer.sv
// Bonus ship controller: random spawn scheduling, lane/direction choice,
// per-frame movement, and hit -> explosion -> score handling.
module bonus_ship_sequencer
    import bonus_ship_pkg::*;
#(
    parameter int          SCREEN_W       = 640,
    parameter int          SHIP_W         = 64,
    parameter int          SHIP_H         = 32,
    parameter int          NUM_LANES      = 2,
    parameter int          LANE_Y0        = 64,
    parameter int          LANE_PITCH     = 40,
    parameter int          SPEED_PX       = 4,
    parameter int          SPAWN_MIN      = 320,
    parameter int          SPAWN_MAX      = 500,
    parameter int          EXPLODE_FRAMES = 16,
    parameter int          DIR_MODE       = 1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        hit,
    input  logic [10:0] alienMatrixYPosition,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        active,
    output logic        exploding,
    output logic        scorePulse,
    output logic [8:0]  scoreValue
);

    localparam int                RMASK   = spawnMask(SPAWN_MAX - SPAWN_MIN + 1);
    localparam int                EW      = $clog2(EXPLODE_FRAMES + 1);
    localparam logic signed [10:0] X_LEFT  = 11'(-SHIP_W);
    localparam logic signed [10:0] X_RIGHT = 11'(SCREEN_W);
    localparam logic signed [10:0] STEP    = 11'(SPEED_PX);

    shipState_t state, stateNext;

    logic [15:0]           lfsr;
    logic [15:0]           frameCnt;
    logic [15:0]           frameReload;
    logic [16:0]           reloadSum;
    logic [EW-1:0]         explodeCnt;
    logic signed [10:0]    xPos;
    logic [10:0]           yPos;
    logic                  moveR2L;
    logic                  dirR2L;
    logic                  spawnR2L;
    logic                  flyDone;
    logic [NUM_LANES-1:0]  laneFree;
    logic                  laneFound;
    logic [1:0]            laneSel;

    logic loadFrame, countDown, spawn, moveX, takeHit, explodeDown;

    bonus_lfsr16 uLfsr (
        .clk    (clk),
        .resetN (resetN),
        .seed   (LFSR_SEED),
        .q      (lfsr)
    );

    assign reloadSum   = 17'(SPAWN_MIN) + 17'(lfsr & 16'(RMASK));
    assign frameReload = (reloadSum > 17'(SPAWN_MAX)) ? 16'(SPAWN_MAX) : reloadSum[15:0];

    assign spawnR2L = (DIR_MODE == 0) ? 1'b0 : (DIR_MODE == 1) ? dirR2L : lfsr[4];
    assign flyDone  = moveR2L ? (xPos <= X_LEFT) : (xPos >= X_RIGHT);

    // A lane is usable only while the alien matrix top is strictly below the ship's bottom edge.
    always_comb begin
        laneFree = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            laneFree[l] = int'(alienMatrixYPosition) > (LANE_Y0 + l * LANE_PITCH + SHIP_H);
        end
    end

    // Walk the search order backwards so the last hit written is the first lane after the random start.
    always_comb begin
        laneFound = 1'b0;
        laneSel   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (laneFree[(int'(lfsr[1:0]) + i) % NUM_LANES]) begin
                laneFound = 1'b1;
                laneSel   = 2'((int'(lfsr[1:0]) + i) % NUM_LANES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) state <= IDLE;
        else        state <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext   = state;
        loadFrame   = 1'b0;
        countDown   = 1'b0;
        spawn       = 1'b0;
        moveX       = 1'b0;
        takeHit     = 1'b0;
        explodeDown = 1'b0;
        if (!playGame) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    stateNext = WAIT;
                    loadFrame = 1'b1;
                end
                WAIT: begin
                    if (startOfFrame) begin
                        if (frameCnt != '0) begin
                            countDown = 1'b1;
                        end else if (laneFound) begin
                            stateNext = FLY;
                            spawn     = 1'b1;
                        end else begin
                            loadFrame = 1'b1;
                        end
                    end
                end
                FLY: begin
                    if (hit) begin
                        stateNext = EXPLODE;
                        takeHit   = 1'b1;
                    end else if (flyDone) begin
                        stateNext = WAIT;
                        loadFrame = 1'b1;
                    end else if (startOfFrame) begin
                        moveX = 1'b1;
                    end
                end
                EXPLODE: begin
                    if (startOfFrame) begin
                        if (explodeCnt == '0) begin
                            stateNext = WAIT;
                            loadFrame = 1'b1;
                        end else begin
                            explodeDown = 1'b1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            xPos       <= '0;
            yPos       <= 11'(LANE_Y0);
            frameCnt   <= '0;
            explodeCnt <= '0;
            moveR2L    <= 1'b0;
            dirR2L     <= 1'b0;
            scorePulse <= 1'b0;
            scoreValue <= '0;
        end else begin
            scorePulse <= takeHit;
            if (loadFrame)      frameCnt <= frameReload;
            else if (countDown) frameCnt <= frameCnt - 16'd1;

            if (spawn) begin
                yPos    <= 11'(LANE_Y0 + int'(laneSel) * LANE_PITCH);
                xPos    <= spawnR2L ? X_RIGHT : X_LEFT;
                moveR2L <= spawnR2L;
                if (DIR_MODE == 1) dirR2L <= ~dirR2L;
            end else if (moveX) begin
                xPos <= moveR2L ? (xPos - STEP) : (xPos + STEP);
            end

            if (takeHit) begin
                scoreValue <= SCORE_TABLE[lfsr[3:2]];
                explodeCnt <= EW'(EXPLODE_FRAMES - 1);
            end else if (explodeDown) begin
                explodeCnt <= explodeCnt - EW'(1);
            end
        end
    end

    assign topLeftX  = xPos;
    assign topLeftY  = yPos;
    assign active    = (state == FLY);
    assign exploding = (state == EXPLODE);

endmodule
